hwt_input_cond: RTL and testbench

Input conditioning stage that sits directly upstream of the hwt combinational block and drives its A, B, C, D inputs.
- Four raw asynchronous inputs (switches or off-chip lines) are synchronised, then individually debounced.
- Presents a glitch-free registered vector, so hwt's output Y = D & (C ^ (A & B)) only changes on clean, qualified input transitions.
- Also emits a change strobe and a saturating event counter for status/debug.

---
 rtl/hwt_input_cond_if.sv | 28 ++
 rtl/hwt_input_cond.sv | 88 ++++++++
 tb/tb_hwt_input_cond.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hwt_input_cond_if.sv
// Signal bundle between the raw input pins and the hwt input conditioner.
// master drives raw inputs and control; slave returns conditioned outputs.
interface hwt_input_cond_if #(
    parameter int EVT_W = 8
);
    logic             a_raw;
    logic             b_raw;
    logic             c_raw;
    logic             d_raw;
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             chg;
    logic [EVT_W-1:0] evt_cnt;

    modport master (
        output a_raw, b_raw, c_raw, d_raw, en, clr,
        input  a, b, c, d, chg, evt_cnt
    );

    modport slave (
        input  a_raw, b_raw, c_raw, d_raw, en, clr,
        output a, b, c, d, chg, evt_cnt
    );
endinterface

// File: rtl/hwt_input_cond.sv
// Synchronise and debounce four raw inputs feeding hwt's A..D,
// with a registered change strobe and a saturating event counter.
module hwt_input_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EVT_W           = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    hwt_input_cond_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       s;
    logic [3:0]       q;
    logic [3:0]       flip;
    logic [3:0]       sync [SYNC_STAGES];
    logic [CW-1:0]    cnt  [4];
    logic             chg_q;
    logic [EVT_W-1:0] evt_q;

    assign raw = {io.d_raw, io.c_raw, io.b_raw, io.a_raw};
    assign s   = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
        end else begin
            sync[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    // A channel qualifies once it has differed for DEBOUNCE_CYCLES edges
    always_comb begin
        flip = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i] = io.en && (s[i] != q[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!io.en || (s[i] == q[i])) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    q[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
            evt_q <= '0;
        end else begin
            chg_q <= |flip;
            if (io.clr) begin
                evt_q <= '0;
            end else if ((|flip) && (evt_q != '1)) begin
                evt_q <= evt_q + EVT_W'(1);
            end
        end
    end

    assign io.a       = q[0];
    assign io.b       = q[1];
    assign io.c       = q[2];
    assign io.d       = q[3];
    assign io.chg     = chg_q;
    assign io.evt_cnt = evt_q;
endmodule

// File: tb/tb_hwt_input_cond.sv
// Directed bench for hwt_input_cond with a flip-event scoreboard.
// Expected {d,c,b,a, evt_cnt} is queued at stimulus and popped on chg.
module tb_hwt_input_cond;
    localparam int EVT_W = 8;

    typedef struct packed {
        logic [3:0]       v;
        logic [EVT_W-1:0] e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hwt_input_cond_if #(.EVT_W(EVT_W)) io ();

    hwt_input_cond #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .EVT_W          (EVT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    int               n_run  = 0;
    int               n_fail = 0;
    int               n_chg  = 0;
    int               snap;
    exp_t             sb[$];
    logic [3:0]       m;
    logic [EVT_W-1:0] me;

    function automatic logic [3:0] outs();
        return {io.d, io.c, io.b, io.a};
    endfunction

    function automatic logic hwt_y(input logic [3:0] v);
        return v[3] & (v[2] ^ (v[0] & v[1]));
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {io.d_raw, io.c_raw, io.b_raw, io.a_raw} = v;
    endtask

    task automatic expect_flip(input logic [3:0] v,
                               input bit clr_hit = 1'b0);
        exp_t t;
        m = v;
        if (clr_hit) me = '0;
        else if (me != '1) me = me + 1'b1;
        t.v = v;
        t.e = me;
        sb.push_back(t);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && io.chg === 1'b1) begin
            exp_t t;
            n_chg++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                chk("sb_vec", 32'(outs()), 32'(t.v));
                chk("sb_evt", 32'(io.evt_cnt), 32'(t.e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        set_raw(4'b0000);
        io.en  = 1'b1;
        io.clr = 1'b0;
        m      = '0;
        me     = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_out", 32'(outs()), 0);
        chk("rst_chg", 32'(io.chg), 0);
        chk("rst_evt", 32'(io.evt_cnt), 0);

        // clean change with latency check
        io.a_raw = 1'b1;
        expect_flip(4'b0001);
        tick(5);
        chk("lat_e5", 32'(io.a), 0);
        tick(1);
        chk("lat_e6", 32'(io.a), 1);
        chk("lat_chg", 32'(io.chg), 1);
        chk("lat_evt", 32'(io.evt_cnt), 1);
        tick(1);
        chk("chg_1cyc", 32'(io.chg), 0);

        // 3-cycle glitch is rejected
        snap = n_chg;
        io.b_raw = 1'b1;
        tick(3);
        io.b_raw = 1'b0;
        tick(10);
        chk("glitch_b", 32'(io.b), 0);
        chk("glitch_chg", 32'(n_chg - snap), 0);
        chk("glitch_evt", 32'(io.evt_cnt), 32'(me));

        // 4-cycle pulse qualifies, then returns
        io.b_raw = 1'b1;
        expect_flip(4'b0011);
        tick(4);
        io.b_raw = 1'b0;
        expect_flip(4'b0001);
        tick(2);
        chk("pulse4_hi", 32'(io.b), 1);
        tick(3);
        chk("pulse4_hold", 32'(io.b), 1);
        tick(1);
        chk("pulse4_lo", 32'(io.b), 0);
        chk("pulse4_evt", 32'(io.evt_cnt), 3);
        tick(2);

        // simultaneous c and d
        snap = n_chg;
        io.c_raw = 1'b1;
        io.d_raw = 1'b1;
        expect_flip(4'b1101);
        tick(6);
        chk("simul_out", 32'(outs()), 32'(4'b1101));
        tick(3);
        chk("simul_chg", 32'(n_chg - snap), 1);
        chk("simul_evt", 32'(io.evt_cnt), 4);
        chk("y_cd", 32'(hwt_y(outs())), 1);

        io.b_raw = 1'b1;
        io.c_raw = 1'b0;
        expect_flip(4'b1011);
        tick(8);
        chk("bc_out", 32'(outs()), 32'(4'b1011));
        chk("y_abd", 32'(hwt_y(outs())), 1);

        // enable freeze
        io.en = 1'b0;
        snap = n_chg;
        for (int i = 0; i < 20; i++) begin
            io.d_raw = ~io.d_raw;
            tick(1);
        end
        chk("en0_d", 32'(io.d), 1);
        chk("en0_chg", 32'(n_chg - snap), 0);
        io.d_raw = 1'b0;
        tick(3);
        chk("en0_hold", 32'(io.d), 1);
        io.en = 1'b1;
        expect_flip(4'b0011);
        tick(3);
        chk("en1_e3", 32'(io.d), 1);
        tick(1);
        chk("en1_e4", 32'(io.d), 0);
        tick(2);

        // saturation
        for (int i = 0; i < 260; i++) begin
            io.a_raw = ~io.a_raw;
            expect_flip(m ^ 4'b0001);
            tick(5);
        end
        tick(5);
        chk("sat_evt", 32'(io.evt_cnt), 255);

        // clr coincident with a flip
        io.a_raw = ~io.a_raw;
        expect_flip(m ^ 4'b0001, 1'b1);
        tick(5);
        io.clr = 1'b1;
        tick(1);
        io.clr = 1'b0;
        chk("clr_evt", 32'(io.evt_cnt), 0);
        chk("clr_a", 32'(io.a), 32'(m[0]));
        tick(3);
        io.a_raw = ~io.a_raw;
        expect_flip(m ^ 4'b0001);
        tick(8);
        chk("post_clr_evt", 32'(io.evt_cnt), 1);

        // asynchronous reset mid-clock
        set_raw(4'b1111);
        expect_flip(4'b1111);
        tick(8);
        chk("all_ones", 32'(outs()), 32'(4'b1111));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(outs()), 0);
        chk("arst_chg", 32'(io.chg), 0);
        chk("arst_evt", 32'(io.evt_cnt), 0);
        m  = '0;
        me = '0;

        // reset mid-debounce discards partial count
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_deb", 32'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_flip(4'b1111);
        tick(5);
        chk("restart_e5", 32'(outs()), 0);
        tick(1);
        chk("restart_e6", 32'(outs()), 32'(4'b1111));
        chk("restart_evt", 32'(io.evt_cnt), 1);
        tick(3);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
